// File: rtl/sqrt_csa_pipe_pkg.sv
// Shared elaboration helpers for the pipelined square-root carry-select adder.
//
// The operand is cut into blocks of nominal width 2, 3, 4, ... bits; the last
// block is truncated so the blocks exactly cover WIDTH bits. Pipeline stages
// each evaluate a fixed number of consecutive blocks.
//
// Functions:
//   nblk(width)                   number of carry-select blocks
//   blk_lo(i)                     LSB position of block i
//   blk_w(i, width)               width of block i (last one truncated)
//   nstage(width, sb)             number of pipeline stages for sb blocks/stage
//   stage_mask(k, width, sb)      bit mask of the sum bits produced by stage k
package sqrt_csa_pkg;

    function automatic int nblk(input int width);
        int n;
        int covered;
        n       = 0;
        covered = 0;
        for (int i = 0; i < 64; i++) begin
            if (covered < width) begin
                covered = covered + i + 2;
                n       = n + 1;
            end
        end
        return n;
    endfunction

    // Blocks 0..i-1 have widths 2..i+1, so block i starts at their sum.
    function automatic int blk_lo(input int i);
        return (i * (i + 3)) / 2;
    endfunction

    function automatic int blk_w(input int i, input int width);
        int rem;
        rem = width - blk_lo(i);
        return (rem < i + 2) ? rem : i + 2;
    endfunction

    function automatic int nstage(input int width, input int sb);
        return (nblk(width) + sb - 1) / sb;
    endfunction

    function automatic logic [63:0] stage_mask(input int k, input int width, input int sb);
        logic [63:0] m;
        int          lo;
        int          w;
        m = '0;
        for (int i = 0; i < nblk(width); i++) begin
            if (i / sb == k) begin
                lo = blk_lo(i);
                w  = blk_w(i, width);
                for (int j = 0; j < 64; j++) begin
                    if (j >= lo && j < lo + w) begin
                        m[j] = 1'b1;
                    end
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/sqrt_csa_pipe_if.sv
// Operand/result handshake bundle for sqrt_csa_pipe.
//
// Input channel : in_valid/in_ready with a, b, cin, sub.
// Output channel: out_valid/out_ready with sum, cout, ovf.
// master = producer of operands and consumer of results (datapath side),
// slave  = the adder pipeline itself.
interface sqrt_csa_pipe_if #(
    parameter int WIDTH = 14
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/sqrt_csa_pipe_csa_block.sv
// One carry-select block of width BW.
//
// Ports:
//   p, g      propagate / generate bits of the block (operand B already
//             conditioned for subtraction)
//   cin_sel   real carry into the block, used only to pick a candidate
//   sum       selected block sum
//   cout      selected carry out of the block's top bit
//   c_msb_in  selected carry into the block's top bit (for overflow)
module csa_block #(
    parameter int BW = 2
) (
    input  logic [BW-1:0] p,
    input  logic [BW-1:0] g,
    input  logic          cin_sel,
    output logic [BW-1:0] sum,
    output logic          cout,
    output logic          c_msb_in
);
    logic [BW:0] c0;
    logic [BW:0] c1;

    // Two speculative ripple chains, one assuming carry-in 0 and one assuming
    // carry-in 1; both settle before the real carry arrives.
    always_comb begin
        c0    = '0;
        c1    = '0;
        c0[0] = 1'b0;
        c1[0] = 1'b1;
        for (int j = 0; j < BW; j++) begin
            c0[j+1] = g[j] | (p[j] & c0[j]);
            c1[j+1] = g[j] | (p[j] & c1[j]);
        end
    end

    assign sum      = cin_sel ? (p ^ c1[BW-1:0]) : (p ^ c0[BW-1:0]);
    assign cout     = cin_sel ? c1[BW] : c0[BW];
    assign c_msb_in = cin_sel ? c1[BW-1] : c0[BW-1];

endmodule

// File: rtl/sqrt_csa_pipe.sv
// Pipelined square-root carry-select adder/subtractor.
//
// Computes {cout, sum} = a + (sub ? ~b : b) + (sub ? 1 : cin) modulo 2^WIDTH,
// plus a signed-overflow flag. Blocks of width 2, 3, 4, ... are grouped
// STAGE_BLOCKS per pipeline stage; latency equals the number of stages.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (drops all in-flight beats)
//   bus    slave side of sqrt_csa_pipe_if: in_valid/in_ready/a/b/cin/sub and
//          out_valid/out_ready/sum/cout/ovf
module sqrt_csa_pipe
    import sqrt_csa_pkg::*;
#(
    parameter int WIDTH        = 14,
    parameter int STAGE_BLOCKS = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    sqrt_csa_pipe_if.slave bus
);
    localparam int NBLK = nblk(WIDTH);
    localparam int S    = nstage(WIDTH, STAGE_BLOCKS);

    // Stage registers: stage k holds the beat after blocks of stage k ran.
    logic [S-1:0]            r_v;
    logic [S-1:0][WIDTH-1:0] r_a;
    logic [S-1:0][WIDTH-1:0] r_b;
    logic [S-1:0][WIDTH-1:0] r_sum;
    logic [S-1:0]            r_carry;
    logic [S-1:0]            r_cmsb;

    // Inputs seen by the combinational logic of stage k.
    logic [S-1:0]            src_v;
    logic [S-1:0][WIDTH-1:0] src_a;
    logic [S-1:0][WIDTH-1:0] src_b;
    logic [S-1:0][WIDTH-1:0] src_sum;
    logic [S-1:0]            src_carry;
    logic [S-1:0]            src_cmsb;

    logic [S-1:0][WIDTH-1:0] st_mask;
    logic [S-1:0]            nxt_carry;
    logic [S-1:0]            nxt_cmsb;

    logic [WIDTH-1:0]        bsum;
    logic [NBLK-1:0]         blk_cin;
    logic [NBLK-1:0]         blk_cout;
    logic [NBLK-1:0]         blk_cmsb;

    logic                    adv;
    logic                    unused_ok;

    // The whole pipe moves together whenever the output slot is free or
    // being drained; bubbles travel like beats.
    assign adv          = !r_v[S-1] || bus.out_ready;
    assign bus.in_ready = adv;

    assign bus.out_valid = r_v[S-1];
    assign bus.sum       = r_sum[S-1];
    assign bus.cout      = r_carry[S-1];
    assign bus.ovf       = r_carry[S-1] ^ r_cmsb[S-1];

    // Per-stage wiring: stage 0 takes the conditioned operands straight from
    // the bus, later stages take the previous register.
    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int LAST = ((k + 1) * STAGE_BLOCKS - 1 < NBLK - 1) ?
                              (k + 1) * STAGE_BLOCKS - 1 : NBLK - 1;
        localparam logic [WIDTH-1:0] MASK = WIDTH'(stage_mask(k, WIDTH, STAGE_BLOCKS));

        assign st_mask[k]   = MASK;
        assign nxt_carry[k] = blk_cout[LAST];

        // Only the stage holding the top block knows the carry into the MSB.
        if (k == S - 1) begin : g_msb
            assign nxt_cmsb[k] = blk_cmsb[NBLK-1];
        end else begin : g_pass
            assign nxt_cmsb[k] = src_cmsb[k];
        end

        if (k == 0) begin : g_head
            assign src_v[0]     = bus.in_valid;
            assign src_a[0]     = bus.a;
            assign src_b[0]     = bus.sub ? ~bus.b : bus.b;
            assign src_sum[0]   = '0;
            assign src_carry[0] = bus.sub ? 1'b1 : bus.cin;
            assign src_cmsb[0]  = 1'b0;
        end else begin : g_body
            assign src_v[k]     = r_v[k-1];
            assign src_a[k]     = r_a[k-1];
            assign src_b[k]     = r_b[k-1];
            assign src_sum[k]   = r_sum[k-1];
            assign src_carry[k] = r_carry[k-1];
            assign src_cmsb[k]  = r_cmsb[k-1];
        end
    end

    // Carry-select blocks; within a stage each block's carry-in is the
    // selected carry of its neighbour, the first block uses the stage carry.
    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        localparam int LO = blk_lo(i);
        localparam int BW = blk_w(i, WIDTH);
        localparam int K  = i / STAGE_BLOCKS;

        logic [BW-1:0] pa;
        logic [BW-1:0] pb;

        assign pa = src_a[K][LO +: BW];
        assign pb = src_b[K][LO +: BW];

        if (i % STAGE_BLOCKS == 0) begin : g_first
            assign blk_cin[i] = src_carry[K];
        end else begin : g_chain
            assign blk_cin[i] = blk_cout[i-1];
        end

        csa_block #(
            .BW(BW)
        ) u_blk (
            .p       (pa ^ pb),
            .g       (pa & pb),
            .cin_sel (blk_cin[i]),
            .sum     (bsum[LO +: BW]),
            .cout    (blk_cout[i]),
            .c_msb_in(blk_cmsb[i])
        );
    end

    // Operand bits outside a stage's window and the last stage's operand
    // copy are dead after elaboration; tie them off here.
    assign unused_ok = ^{src_a, src_b, src_cmsb, blk_cmsb, r_a, r_b};

    // Stage registers: each stage merges its freshly computed sum bits into
    // the partial sum and forwards the running carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < S; k++) begin
                r_v[k]     <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k]   <= '0;
                r_carry[k] <= 1'b0;
                r_cmsb[k]  <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < S; k++) begin
                r_v[k]     <= src_v[k];
                r_a[k]     <= src_a[k];
                r_b[k]     <= src_b[k];
                r_sum[k]   <= (src_sum[k] & ~st_mask[k]) | (bsum & st_mask[k]);
                r_carry[k] <= nxt_carry[k];
                r_cmsb[k]  <= nxt_cmsb[k];
            end
        end
    end

endmodule

// File: doc/sqrt_csa_pipe.md
Name: sqrt_csa_pipe

Overview:
- Parametrised, pipelined square-root carry-select adder/subtractor. It is the successor to the team's fixed 14-bit combinational SQRT CSA.
- Operand width is generic. Block sizes grow 2, 3, 4, … with the final block truncated to fit.
- Pipeline registers are inserted every STAGE_BLOCKS blocks.
- Valid/ready handshakes on both sides. Adds an add/subtract mode and a signed-overflow flag.
- Sits between operand-fetch logic and result writeback in the datapath.

Parameters:
- WIDTH, 14, operand/sum width in bits; legal range 4..64.
- STAGE_BLOCKS, 2, number of carry-select blocks evaluated per pipeline stage; legal range 1..NBLK.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  0: A+B+cin; 1: A+~B+1
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of the MSB; for sub, 1 = no borrow
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Block partition:
  - Block i (i = 0, 1, …) nominally has size i+2 and starts where block i-1 ends.
  - The last block is truncated to WIDTH minus the bits already covered.
  - NBLK = number of blocks. WIDTH=14 gives 2,3,4,5 (NBLK=4). WIDTH=32 gives 2,3,4,5,6,7,5 (NBLK=7).
- Per block:
  - Compute p = a^b' and g = a&b', where b' = sub ? ~b : b.
  - Compute both candidate sums and carries for block carry-in 0 and 1.
  - Select with the real incoming carry.
  - The block-0 carry-in is sub ? 1 : cin.
- Pipeline:
  - S = ceil(NBLK/STAGE_BLOCKS) register stages. Stage k evaluates blocks k*STAGE_BLOCKS through k*STAGE_BLOCKS+STAGE_BLOCKS-1.
  - Each stage register holds: valid bit, unprocessed operand bits (already b'-conditioned), completed sum bits, running carry, and the carry into the current MSB.
  - The final stage register drives sum, cout, ovf and out_valid directly. No combinational path from a/b to the outputs.
  - Latency is exactly S cycles from the in_valid&&in_ready edge to out_valid (WIDTH=14, STAGE_BLOCKS=2 → 2 cycles).
- Handshake:
  - adv = !out_valid || out_ready. in_ready = adv (combinational; no dependence on in_valid).
  - When adv=1, every stage shifts forward one slot. Stage 0 loads {in_valid, operands}.
  - When adv=0, all stages hold. out_valid, sum, cout and ovf stay stable until out_ready.
  - Bubbles (valid=0) propagate and are not compressed.
  - Throughput is 1 beat/cycle with out_ready held high.
- Arithmetic:
  - All arithmetic is modulo 2^WIDTH.
  - ovf is computed from the carry into bit WIDTH-1 and cout, per beat.
  - sum/cout/ovf are don't-care when out_valid=0 but must hold their last values (no X).
- Reset (rst_n=0 at a clock edge):
  - All stage valids, out_valid, sum, cout and ovf become 0.
  - In-flight beats are dropped.
  - in_ready reads 1 in the first cycle after reset release.
- Simultaneous events:
  - out_ready and in_valid in the same cycle with a full pipe: the output pops and the input enters in the same edge, so there is no stall cycle.

Decomposition:
- Package sqrt_csa_pkg holds:
  - constant function nblk(width);
  - function blk_lo(i) and blk_w(i, width) for block start and width;
  - function nstage(width, stage_blocks).
- One sub-module, csa_block (parameter BW):
  - inputs p, g, cin_sel;
  - outputs sum[BW-1:0], cout, and c_msb_in (carry into its top bit);
  - internally two ripple chains (ci=0, ci=1) plus a mux.
- Top-level generates blocks and stage registers.

Test Plan:
- WIDTH=14: a=0x3FFF, b=0x0001, cin=0, sub=0 → after 2 cycles sum=0x0000, cout=1, ovf=0.
- WIDTH=14: a=0x1FFF, b=0x0001, sub=0 → sum=0x2000, cout=0, ovf=1. Then a=0x0005, b=0x0007, sub=1 → sum=0x3FFE, cout=0, ovf=0.
- Back-pressure: 4 back-to-back beats (1+1, 2+2, 3+3, 4+4) with out_ready low for 3 cycles → results 2, 4, 6, 8 in order, none lost or duplicated, outputs stable while stalled, in_ready low while stalled with a full pipe.
- Reset mid-flight: 2 beats in the pipe, rst_n=0 for one edge → out_valid=0 next cycle, and no stale result ever appears after release.
- WIDTH=32, STAGE_BLOCKS=2: latency 4. 0xFFFFFFFF+0x00000000 with cin=1 → sum=0, cout=1, ovf=0.
- Random sweep: 10k random a/b/cin/sub with random out_ready → every result matches the golden model {cout,sum} = a + (sub ? ~b : b) + (sub ? 1 : cin), and ovf matches the signed overflow rule.
